// File: rtl/regfile_pkg.sv
// Shared widths and the write-request record for the register-file write path.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/pending_scoreboard.sv
// Pending-destination bit vector: one bit per register, r0 never pending.
// A set and a clear of the same register in one cycle leave the bit set.
module pending_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rd_a_addr_i,
    input  logic [ADDR_W-1:0] rd_b_addr_i,
    input  logic [ADDR_W-1:0] rd_c_addr_i,
    output logic              pend_a_o,
    output logic              pend_b_o,
    output logic              pend_c_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear is applied before set so that the set wins on a collision.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pend_a_o = pending_q[rd_a_addr_i];
    assign pend_b_o = pending_q[rd_b_addr_i];
    assign pend_c_o = pending_q[rd_c_addr_i];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges MEM/WB writeback (priority) and long-latency results onto the register-file
// write port, with hazard/starvation stall. ARB_STATS_EN adds activity counters.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              pipe_we_i,
    input  logic [ADDR_W-1:0] pipe_addr_i,
    input  logic [DATA_W-1:0] pipe_data_i,
    input  logic              lu_valid_i,
    input  logic [ADDR_W-1:0] lu_addr_i,
    input  logic [DATA_W-1:0] lu_data_i,
    output logic              lu_ready_o,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              stall_o,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_pipe_wr_o,
    output logic [15:0]       stat_lu_wr_o,
    output logic [15:0]       stat_stall_o
`endif
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic              hold_v_q, hold_v_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    wr_req_t           out_q, out_d;

    logic pipe_eff;
    logic drain;
    logic lu_wr;
    logic sb_set;
    logic pend_rs, pend_rt, pend_rd;

    assign pipe_eff   = pipe_we_i && (pipe_addr_i != ZERO_REG);
    assign drain      = !pipe_eff && hold_v_q;
    assign lu_wr      = drain && (hold_addr_q != ZERO_REG);
    assign sb_set     = issue_i && (issue_addr_i != ZERO_REG);
    assign lu_ready_o = !hold_v_q;

    pending_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .set_i       (sb_set),
        .set_addr_i  (issue_addr_i),
        .clr_i       (drain),
        .clr_addr_i  (hold_addr_q),
        .rd_a_addr_i (rs_addr_i),
        .rd_b_addr_i (rt_addr_i),
        .rd_c_addr_i (rd_addr_i),
        .pend_a_o    (pend_rs),
        .pend_b_o    (pend_rt),
        .pend_c_o    (pend_rd)
    );

    assign stall_o = pend_rs || pend_rt || pend_rd || (starve_q >= LIMIT);

    // Address and data hold their last value whenever no effective write is issued.
    always_comb begin
        hold_v_d    = hold_v_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        starve_d    = starve_q;
        out_d       = out_q;
        out_d.we    = 1'b0;

        if (pipe_eff) begin
            out_d.we   = 1'b1;
            out_d.addr = pipe_addr_i;
            out_d.data = pipe_data_i;
            if (hold_v_q && (starve_q < LIMIT)) begin
                starve_d = starve_q + 1'b1;
            end
        end else if (hold_v_q) begin
            if (lu_wr) begin
                out_d.we   = 1'b1;
                out_d.addr = hold_addr_q;
                out_d.data = hold_data_q;
            end
            hold_v_d = 1'b0;
            starve_d = '0;
        end

        if (lu_valid_i && !hold_v_q) begin
            hold_v_d    = 1'b1;
            hold_addr_d = lu_addr_i;
            hold_data_d = lu_data_i;
        end

        if (!hold_v_q) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_v_q    <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            starve_q    <= '0;
            out_q       <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            starve_q    <= starve_d;
            out_q       <= out_d;
        end
    end

    assign RegWrite_o = out_q.we;
    assign RDaddr_o   = out_q.addr;
    assign RDdata_o   = out_q.data;

`ifdef ARB_STATS_EN
    logic [15:0] stat_pipe_q, stat_lu_q, stat_stall_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_pipe_q  <= '0;
            stat_lu_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (pipe_eff) stat_pipe_q  <= stat_pipe_q + 16'd1;
            if (lu_wr)    stat_lu_q    <= stat_lu_q + 16'd1;
            if (stall_o)  stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_pipe_wr_o = stat_pipe_q;
    assign stat_lu_wr_o   = stat_lu_q;
    assign stat_stall_o   = stat_stall_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus hand-written corner sequences.
// Stats checks compile in only when ARB_STATS_EN is defined.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        issue;
    logic [4:0]  issue_addr;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        stall;
    logic        reg_write;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
`ifdef ARB_STATS_EN
    logic [15:0] stat_pipe, stat_lu, stat_stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .pipe_we_i    (pipe_we),
        .pipe_addr_i  (pipe_addr),
        .pipe_data_i  (pipe_data),
        .lu_valid_i   (lu_valid),
        .lu_addr_i    (lu_addr),
        .lu_data_i    (lu_data),
        .lu_ready_o   (lu_ready),
        .issue_i      (issue),
        .issue_addr_i (issue_addr),
        .rs_addr_i    (rs_addr),
        .rt_addr_i    (rt_addr),
        .rd_addr_i    (rd_addr),
        .stall_o      (stall),
        .RegWrite_o   (reg_write),
        .RDaddr_o     (rd_waddr),
        .RDdata_o     (rd_wdata)
`ifdef ARB_STATS_EN
        ,
        .stat_pipe_wr_o (stat_pipe),
        .stat_lu_wr_o   (stat_lu),
        .stat_stall_o   (stat_stall)
`endif
    );

    typedef struct {
        logic        pWe;
        logic [4:0]  pAddr;
        logic [31:0] pData;
        logic        luV;
        logic [4:0]  luAddr;
        logic [31:0] luData;
        logic        iss;
        logic [4:0]  issAddr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic        eRdy;
        logic        eStall;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
        issue = 1'b0; issue_addr = '0;
        rs_addr = '0; rt_addr = '0; rd_addr = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        pipe_we = v.pWe; pipe_addr = v.pAddr; pipe_data = v.pData;
        lu_valid = v.luV; lu_addr = v.luAddr; lu_data = v.luData;
        issue = v.iss; issue_addr = v.issAddr;
        rs_addr = v.rs; rt_addr = v.rt; rd_addr = v.rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;
        #12;
        checkOutput("reset.we",    32'(reg_write), 32'd0);
        checkOutput("reset.addr",  32'(rd_waddr),  32'd0);
        checkOutput("reset.data",  rd_wdata,       32'd0);
        checkOutput("reset.ready", 32'(lu_ready),  32'd1);
        checkOutput("reset.stall", 32'(stall),     32'd0);
        rst_n = 1'b1;

        //           pWe  pAddr  pData          luV  luAddr luData        iss  issA   rs     rt     rd     eWe  eAddr  eData          eRdy eStall
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'h00001111, 1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 5'd31, 32'hCAFEF00D, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 5'd9,  5'd9,  5'd0,  5'd0,  1'b0, 5'd31, 32'hCAFEF00D, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h1234,    1'b0, 5'd0,  5'd9,  5'd0,  5'd0,  1'b0, 5'd31, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd9,  5'd0,  5'd0,  1'b1, 5'd9,  32'h1234,     1'b1, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 5'd12, 5'd0,  5'd0,  5'd12, 1'b0, 5'd9,  32'h1234,     1'b1, 1'b1};
        vecs[8]  = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd12, 32'hAAAA,    1'b0, 5'd0,  5'd0,  5'd12, 5'd0,  1'b1, 5'd4,  32'h44,       1'b0, 1'b1};
        vecs[9]  = '{1'b1, 5'd6,  32'h66,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd12, 5'd0,  1'b1, 5'd6,  32'h66,       1'b0, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 5'd12, 32'hAAAA,     1'b1, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h5555,    1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 5'd12, 32'hAAAA,     1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 5'd12, 32'hAAAA,     1'b1, 1'b0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("row%0d.we", i),    32'(reg_write), 32'(vecs[i].eWe));
            checkOutput($sformatf("row%0d.addr", i),  32'(rd_waddr),  32'(vecs[i].eAddr));
            checkOutput($sformatf("row%0d.data", i),  rd_wdata,       vecs[i].eData);
            checkOutput($sformatf("row%0d.ready", i), 32'(lu_ready),  32'(vecs[i].eRdy));
            checkOutput($sformatf("row%0d.stall", i), 32'(stall),     32'(vecs[i].eStall));
        end

        // Starvation: r7 held while the pipe keeps winning.
        clearInputs();
        pipe_we = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h101;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77;
        tick();
        checkOutput("starve.capture.ready", 32'(lu_ready), 32'd0);
        checkOutput("starve.capture.stall", 32'(stall),    32'd0);
        lu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pipe_addr = 5'(k + 1);
            pipe_data = 32'(256 + k);
            tick();
            checkOutput($sformatf("starve.loss%0d.addr", k),  32'(rd_waddr), 32'(k + 1));
            checkOutput($sformatf("starve.loss%0d.stall", k), 32'(stall),    (k >= 4) ? 32'd1 : 32'd0);
        end
        clearInputs();
        tick();
        checkOutput("starve.drain.we",    32'(reg_write), 32'd1);
        checkOutput("starve.drain.addr",  32'(rd_waddr),  32'd7);
        checkOutput("starve.drain.data",  rd_wdata,       32'h77);
        checkOutput("starve.drain.ready", 32'(lu_ready),  32'd1);
        checkOutput("starve.drain.stall", 32'(stall),     32'd0);

        // Counter restarts from zero: three further losses must not stall.
        pipe_we = 1'b1; pipe_addr = 5'd2; pipe_data = 32'h202;
        lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'h88;
        tick();
        lu_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checkOutput("restart.stall", 32'(stall), 32'd0);
        clearInputs();
        tick();
        checkOutput("restart.drain.addr", 32'(rd_waddr), 32'd8);
        checkOutput("restart.drain.data", rd_wdata,      32'h88);

        // Set-wins: r3 reissued in the cycle its result drains.
        clearInputs();
        issue = 1'b1; issue_addr = 5'd3;
        tick();
        clearInputs();
        lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h33;
        tick();
        clearInputs();
        issue = 1'b1; issue_addr = 5'd3; rt_addr = 5'd3;
        tick();
        checkOutput("setwins.drain.we",   32'(reg_write), 32'd1);
        checkOutput("setwins.drain.addr", 32'(rd_waddr),  32'd3);
        checkOutput("setwins.stall",      32'(stall),     32'd1);
        issue = 1'b0;
        tick();
        checkOutput("setwins.stall.hold", 32'(stall), 32'd1);
        lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h34;
        tick();
        lu_valid = 1'b0;
        tick();
        checkOutput("setwins.clear.stall", 32'(stall), 32'd0);

        // Reset mid-stream with a write on the port, a held result and a pending register.
        clearInputs();
        issue = 1'b1; issue_addr = 5'd2;
        tick();
        clearInputs();
        pipe_we = 1'b1; pipe_addr = 5'd8; pipe_data = 32'h808;
        lu_valid = 1'b1; lu_addr = 5'd2; lu_data = 32'h22;
        rs_addr = 5'd2;
        tick();
        checkOutput("midrst.pre.we",    32'(reg_write), 32'd1);
        checkOutput("midrst.pre.stall", 32'(stall),     32'd1);
        clearInputs();
        rs_addr = 5'd2;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.we",    32'(reg_write), 32'd0);
        checkOutput("midrst.addr",  32'(rd_waddr),  32'd0);
        checkOutput("midrst.data",  rd_wdata,       32'd0);
        checkOutput("midrst.ready", 32'(lu_ready),  32'd1);
        checkOutput("midrst.stall", 32'(stall),     32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("midrst.after.we",    32'(reg_write), 32'd0);
        checkOutput("midrst.after.stall", 32'(stall),     32'd0);

`ifdef ARB_STATS_EN
        doReset();
        for (int k = 0; k < 10; k++) begin
            pipe_we = 1'b1; pipe_addr = 5'(k + 1); pipe_data = 32'(k);
            tick();
        end
        clearInputs();
        for (int k = 0; k < 2; k++) begin
            lu_valid = 1'b1; lu_addr = 5'd10; lu_data = 32'(k);
            tick();
            lu_valid = 1'b0;
            tick();
        end
        issue = 1'b1; issue_addr = 5'd9;
        tick();
        issue = 1'b0; rs_addr = 5'd9;
        for (int k = 0; k < 4; k++) tick();
        rs_addr = 5'd0;
        tick();
        checkOutput("stats.pipe",  32'(stat_pipe),  32'd10);
        checkOutput("stats.lu",    32'(stat_lu),    32'd2);
        checkOutput("stats.stall", 32'(stat_stall), 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
